// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential 32x32 multiplier.
// State encodings, operand/counter widths, adder and negation helpers.
package mult_seq_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Ripple-carry add/subtract, result carries the carry-out in bit WIDTH.
    function automatic logic [WIDTH:0] add_sub_32(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             sub
    );
        logic [WIDTH-1:0] yy;
        yy = sub ? ~y : y;
        return {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, sub};
    endfunction

    function automatic logic [2*WIDTH-1:0] twoscomp64(
        input logic [2*WIDTH-1:0] x
    );
        return ~x + (2*WIDTH)'(1);
    endfunction

    // Magnitude of an operand; unsigned operands pass through untouched.
    function automatic logic [WIDTH-1:0] magnitude(
        input logic [WIDTH-1:0] x,
        input logic             sgn
    );
        logic [WIDTH:0] neg;
        neg = add_sub_32('0, x, 1'b1);
        return (sgn & x[WIDTH-1]) ? neg[WIDTH-1:0] : x;
    endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Request/response bundle between the control unit and mult_seq.
// master = issuing side, slave = multiplier.
interface mult_seq_if;
    import mult_seq_pkg::*;

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mult_seq_dp.sv
// Multiplier datapath: magnitudes, accumulator, multiplier shifter, sign fix.
// MULT_SEQ_EARLY_EXIT_EN: stop once the multiplier runs out of set bits.
module mult_seq_dp
    import mult_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    input  logic [CNT_W-1:0]   cnt,
    output logic [2*WIDTH-1:0] result,
    output logic               last_step,
    output logic               skip_run
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               neg;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] run_acc;
    logic [WIDTH-1:0]   mplier_nx;

`ifdef MULT_SEQ_EARLY_EXIT_EN
    logic [CNT_W-1:0]   align_amt;
`endif

    // One add-and-shift step plus the run-termination decode.
    always_comb begin
        mag_a     = magnitude(a, is_signed);
        mag_b     = magnitude(b, is_signed);
        sum       = add_sub_32(acc[2*WIDTH-1:WIDTH],
                               mplier[0] ? mcand : '0, 1'b0);
        shifted   = {sum, acc[WIDTH-1:1]};
        mplier_nx = mplier >> 1;
`ifdef MULT_SEQ_EARLY_EXIT_EN
        // Remaining steps would only shift, so apply them all at once.
        align_amt = CNT_W'(WIDTH - 1) - cnt;
        last_step = (mplier_nx == '0);
        skip_run  = (mag_b == '0);
        run_acc   = last_step ? (shifted >> align_amt) : shifted;
`else
        last_step = (cnt == CNT_W'(WIDTH - 1));
        skip_run  = 1'b0;
        run_acc   = shifted;
`endif
        result    = neg ? twoscomp64(acc) : acc;
    end

    // Operand latch, accumulate/shift and final sign correction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
        end else if (load) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            acc    <= '0;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            acc    <= run_acc;
            mplier <= mplier_nx;
        end else if (fix) begin
            acc    <= result;
        end
    end

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-and-add multiplier top: FSM, step counter, HI/LO.
// Build option MULT_SEQ_EARLY_EXIT_EN lives in mult_seq_dp.
module mult_seq
    import mult_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    mult_seq_if.slave  bus
);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    logic               load;
    logic               step;
    logic               fix;
    logic [2*WIDTH-1:0] result;
    logic               last_step;
    logic               skip_run;

    mult_seq_dp u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .fix       (fix),
        .a         (bus.a),
        .b         (bus.b),
        .is_signed (bus.is_signed),
        .cnt       (cnt),
        .result    (result),
        .last_step (last_step),
        .skip_run  (skip_run)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and datapath controls; START only counts when not busy.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        fix      = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = skip_run ? FIX : RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_step) state_nx = FIX;
            end
            FIX: begin
                fix      = 1'b1;
                state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (load) cnt <= '0;
        else if (step) cnt <= cnt + CNT_W'(1);
    end

    // Result registers, written only on the FIX edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (fix) begin
            hi <= result[2*WIDTH-1:WIDTH];
            lo <= result[WIDTH-1:0];
        end
    end

    assign bus.busy = (state == RUN) || (state == FIX);
    assign bus.done = (state == DONE);
    assign bus.hi   = hi;
    assign bus.lo   = lo;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: scoreboard of expected products,
// done timing and busy length; covers both build options.
module tb_mult_seq;
    import mult_seq_pkg::*;

    typedef struct {
        logic [63:0] prod;
        int          edge_n;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   busy_cnt;
    logic [63:0] last_prod;
    exp_t sbq[$];

    mult_seq_if bus();

    mult_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_prod(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int model_lat(input logic [31:0] b, input logic s);
`ifdef MULT_SEQ_EARLY_EXIT_EN
        logic [31:0] mb;
        int n;
        mb = (s && b[31]) ? (32'd0 - b) : b;
        n = 0;
        for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
        return n + 1;
`else
        return (b === 32'hx) ? 0 : 33;
`endif
    endfunction

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                            input logic s);
        exp_t e;
        e.prod   = model_prod(a, b, s);
        e.edge_n = cyc + 1;
        e.lat    = model_lat(b, s);
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = s;
        push_exp(a, b, s);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.is_signed = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    // Monitor: result hold while busy, then product/timing on DONE.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt  = 0;
            last_prod = '0;
        end else begin
            if (bus.busy) begin
                busy_cnt++;
                check("hold", {bus.hi, bus.lo}, last_prod);
            end
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    check("spurious_done", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("product", {bus.hi, bus.lo}, e.prod);
                    check("done_cycle", 64'(cyc), 64'(e.edge_n + e.lat));
                    check("busy_cycles", 64'(busy_cnt), 64'(e.lat));
                    last_prod = e.prod;
                end
                busy_cnt = 0;
            end
        end
    end

    vec_t vecs[$];

    initial begin
        int n;
        n_checks      = 0;
        n_errors      = 0;
        busy_cnt      = 0;
        last_prod     = '0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.is_signed = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;

        vecs.push_back('{32'd3, 32'd5, 1'b0});
        vecs.push_back('{32'hFFFFFFF9, 32'd3, 1'b1});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b1});
        vecs.push_back('{32'h1234, 32'd0, 1'b0});
        vecs.push_back('{32'h1234, 32'd1, 1'b0});
        vecs.push_back('{32'h1234, 32'h80000000, 1'b0});
        vecs.push_back('{32'h7FFFFFFF, 32'h80000000, 1'b1});
        vecs.push_back('{32'hDEADBEEF, 32'h00000000, 1'b1});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{$urandom, $urandom, 1'(i)});

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_idle();
        end

        // START with new operands while busy must be ignored.
        issue(32'h00000021, 32'h80000003, 1'b0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'hCAFEF00D;
        bus.b     = 32'h12345678;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // START held high: second run launches on the DONE edge.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.a         = 32'h00010001;
        bus.b         = 32'hF0000000;
        bus.is_signed = 1'b1;
        push_exp(bus.a, bus.b, bus.is_signed);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 100);
        if (n >= 100) check("b2b_timeout", 64'd1, 64'd0);
        bus.a         = 32'h89ABCDEF;
        bus.b         = 32'h87654321;
        bus.is_signed = 1'b0;
        push_exp(bus.a, bus.b, bus.is_signed);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Reset between edges 10 and 11 of a run.
        issue(32'h55555555, 32'hC0000001, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        sbq.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        issue(32'h00000007, 32'hFFFFFFFA, 1'b1);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
# mult_seq

Sequential 32x32 shift-and-add multiplier for the processor datapath; it produces a 64-bit signed or unsigned product on HI/LO. The block owns an FSM that runs a 32-bit add/subtract datapath one multiplier bit per clock. The ALU/control unit issues a START pulse, watches BUSY, and captures HI/LO on DONE. The MUL instruction uses it, so the rest of the datapath needs no wide combinational multiplier.

## Interface
- WIDTH, 32, operand width; fixed at 32 for this release; the counter width is derived from it.
- CLK  input  1  system clock, all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE or DONE state.
- SIGNED  input  1  1 = operands two's complement, 0 = unsigned; sampled with START.
- A  input  32  multiplicand, sampled with START.
- B  input  32  multiplier, sampled with START.
- BUSY  output  1  high in RUN and FIX states.
- DONE  output  1  one-cycle pulse; HI/LO valid from this cycle on.
- HI  output  32  product bits 63:32.
- LO  output  32  product bits 31:0.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE→RUN on START=1:
  - Latch |A| and |B| into the internal multiplicand and multiplier registers. The magnitude is the two's complement when SIGNED=1 and the operand MSB=1; otherwise the operand is used as-is.
  - Latch sign flag = SIGNED & (A[31]^B[31]).
  - Clear the 64-bit accumulator and the bit counter.
- RUN, each edge:
  - If the multiplier LSB=1, add the multiplicand into accumulator bits 63:32, keeping the carry-out.
  - Shift the accumulator/multiplier pair right one bit, with the carry entering bit 63.
  - Increment the counter.
  - After the WIDTH-th RUN edge, go to FIX.
- FIX, one edge:
  - If the sign flag is set, replace the accumulator with its 64-bit two's complement.
  - Copy the accumulator to HI/LO and go to DONE.
- DONE, one cycle with DONE=1. Next edge: START=1 behaves exactly as IDLE→RUN (back-to-back issue); otherwise go to IDLE.
- START while BUSY=1 is ignored; A/B/SIGNED may change freely during RUN/FIX.
- HI/LO change only on the FIX edge. They hold the previous result throughout a run and until the next FIX.
- Magnitude of 0x80000000 is 2^31, which fits unsigned, so no overflow case exists; the product always fits in 64 bits.
- Unsigned mode never negates, so operand MSBs are magnitude bits.

## Timing
- Reset (RESET=0, asynchronous): state=IDLE, BUSY=0, DONE=0, HI=0, LO=0, accumulator/counter cleared.
- Reset mid-run aborts the operation, discards the partial product, and zeroes HI/LO. After RESET deasserts, the first rising edge with START=1 starts a new run normally.
- Label the START-sampling edge edge 0.
  - RUN occupies edges 1..32 (BUSY=1 from after edge 0).
  - FIX is edge 33.
  - DONE=1 and HI/LO valid after edge 33; BUSY=0 after edge 33.
  - Fixed latency: 33 cycles START→DONE, 34-cycle issue interval with back-to-back START.
- DONE is registered; BUSY is decoded from the state register only.

## Configuration
- MULT_SEQ_EARLY_EXIT_EN defined:
  - RUN ends early once all remaining multiplier bits are zero.
  - If |B|=0 at START, edge 0 goes directly to FIX.
  - In RUN, go to FIX on the edge whose shift leaves the multiplier zero, with the accumulator pre-aligned by the remaining shift count so the result is identical.
  - Latency = n+1 cycles, where n = index of the highest set bit of |B| plus 1 (n=0 for B=0).
- Undefined: fixed 32 RUN cycles, as above.
- The result is bit-identical in both builds.

## Structure
- Shared definitions file holds:
  - state encodings (IDLE=2'b00, RUN=2'b01, FIX=2'b10, DONE=2'b11);
  - WIDTH;
  - counter width (6 bits).
- Top-level mult_seq contains the FSM, counter, BUSY/DONE and HI/LO registers.
- One sub-module, mult_seq_dp: accumulator, multiplier shift register, magnitude conversion and final negation, built on RC_ADD_SUB_32/TWOSCOMP64.

## Test plan
- Unsigned A=3, B=5, START at edge 0 → DONE after edge 33 only, HI=0x00000000, LO=0x0000000F; BUSY=1 for exactly 33 cycles.
- Signed A=0xFFFFFFF9 (-7), B=3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; signed A=B=0xFFFFFFFF → HI=0, LO=1.
- Unsigned A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; signed A=B=0x80000000 → HI=0x40000000, LO=0.
- START and new A/B pulsed at edge 5 during RUN → ignored, original result produced. START held high through DONE → second run begins on the DONE edge, second DONE 34 cycles after the first.
- RESET=0 asserted between edges 10 and 11 → BUSY, DONE, HI, LO all 0 immediately, state IDLE. New START afterward → correct result 33 cycles later.
- With MULT_SEQ_EARLY_EXIT_EN:
  - B=0 → DONE after edge 1, product 0.
  - B=1, A=0x1234 → DONE after edge 2, LO=0x1234.
  - B=0x80000000 unsigned → DONE after edge 33.
